mavg_scheduler: RTL and testbench

Time-multiplexed moving-average engine for the x/y/t sensor channels. It arbitrates between `NUM_CH` sample requesters round-robin, accepts at most one sample per cycle through a req/gnt handshake, and pushes it into that channel's `WINDOW_SIZE`-deep window with a running sum. It publishes a per-channel average and valid flag. It sits between the pad-level sample sources and the chip output mux, and replaces per-channel free-running accumulators with one scheduled update path.

---
 rtl/mavg_scheduler.sv | 118 +++++++++++
 tb/tb_mavg_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mavg_scheduler.sv
// Round-robin scheduled moving-average engine: one sample per cycle enters its channel's window.
// Zero-cycle combinational grant, so results show one cycle after accept; ena=0, flush or FLUSH state block grants.
module mavg_scheduler #(
    parameter int WINDOW_SIZE = 4,
    parameter int SAMPLE_W    = 2,
    parameter int NUM_CH      = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       ena,
    input  logic                       flush,
    input  logic [NUM_CH-1:0]          req,
    input  logic [NUM_CH*SAMPLE_W-1:0] sample,
    output logic [NUM_CH-1:0]          gnt,
    output logic [NUM_CH*SAMPLE_W-1:0] avg,
    output logic [NUM_CH-1:0]          avg_valid,
    output logic [1:0]                 state
);
    localparam int LOG_W = $clog2(WINDOW_SIZE);
    localparam int SUM_W = SAMPLE_W + LOG_W;
    localparam int CNT_W = LOG_W + 1;
    localparam int RR_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        FLUSH = 2'b10
    } state_t;

    state_t              state_q;
    logic [RR_W-1:0]     rr_q;
    logic [RR_W-1:0]     rr_d;
    logic [RR_W-1:0]     gnt_idx;
    logic [RR_W-1:0]     cand;
    logic                gnt_any;
    logic [SAMPLE_W-1:0] win_q [NUM_CH][WINDOW_SIZE];
    logic [SUM_W-1:0]    sum_q [NUM_CH];
    logic [CNT_W-1:0]    cnt_q [NUM_CH];

    // Reset is folded into the gate so no grant escapes while rst_n is held low.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (rst_n && ena && !flush && state_q != FLUSH) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cand = RR_W'((int'(rr_q) + i) % NUM_CH);
                if (!gnt_any && req[cand]) begin
                    gnt_any = 1'b1;
                    gnt_idx = cand;
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (gnt_any) begin
            gnt[gnt_idx] = 1'b1;
        end
        rr_d = (int'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            rr_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sum_q[c] <= '0;
                cnt_q[c] <= '0;
                for (int j = 0; j < WINDOW_SIZE; j++) begin
                    win_q[c][j] <= '0;
                end
            end
        end else if (flush && state_q != FLUSH) begin
            state_q <= FLUSH;
            rr_q    <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                sum_q[c] <= '0;
                cnt_q[c] <= '0;
                for (int j = 0; j < WINDOW_SIZE; j++) begin
                    win_q[c][j] <= '0;
                end
            end
        end else if (state_q == FLUSH) begin
            state_q <= IDLE;
        end else if (gnt_any) begin
            state_q <= RUN;
            rr_q    <= rr_d;
            for (int c = 0; c < NUM_CH; c++) begin
                if (gnt[c]) begin
                    // Slot WINDOW_SIZE-1 holds the oldest sample; cleared slots are 0 during fill.
                    win_q[c][0] <= sample[c*SAMPLE_W +: SAMPLE_W];
                    for (int j = 1; j < WINDOW_SIZE; j++) begin
                        win_q[c][j] <= win_q[c][j-1];
                    end
                    sum_q[c] <= sum_q[c] + SUM_W'(sample[c*SAMPLE_W +: SAMPLE_W])
                                - SUM_W'(win_q[c][WINDOW_SIZE-1]);
                    if (cnt_q[c] != CNT_W'(WINDOW_SIZE)) begin
                        cnt_q[c] <= cnt_q[c] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        avg       = '0;
        avg_valid = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            avg[c*SAMPLE_W +: SAMPLE_W] = sum_q[c][SUM_W-1:LOG_W];
            avg_valid[c]                = (cnt_q[c] == CNT_W'(WINDOW_SIZE));
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mavg_scheduler.sv
// Directed and randomized bench for mavg_scheduler against a queue-based window model.
module tb_mavg_scheduler;
    localparam int W  = 4;
    localparam int SW = 2;
    localparam int N  = 3;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ena;
    logic          flush;
    logic [N-1:0]  req;
    logic [N*SW-1:0] sample;
    logic [N-1:0]  gnt;
    logic [N*SW-1:0] avg;
    logic [N-1:0]  avg_valid;
    logic [1:0]    state;

    always #5 clk = ~clk;

    mavg_scheduler #(.WINDOW_SIZE(W), .SAMPLE_W(SW), .NUM_CH(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .flush     (flush),
        .req       (req),
        .sample    (sample),
        .gnt       (gnt),
        .avg       (avg),
        .avg_valid (avg_valid),
        .state     (state)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: each channel's window as a queue of the last W samples, oldest first.
    int m_win [N][$];
    int m_cnt [N];
    int m_rr;
    int m_state;
    logic [N-1:0] obs_gnt;
    logic [1:0]   obs_state;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic m_clear();
        m_rr = 0;
        for (int c = 0; c < N; c++) begin
            m_win[c].delete();
            for (int j = 0; j < W; j++) m_win[c].push_back(0);
            m_cnt[c] = 0;
        end
    endtask

    function automatic int m_sum(input int c);
        int s = 0;
        foreach (m_win[c][j]) s += m_win[c][j];
        return s;
    endfunction

    function automatic int exp_grant();
        if (!rst_n || !ena || flush || m_state == 2) return -1;
        for (int i = 0; i < N; i++) begin
            int c = (m_rr + i) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_outputs();
        for (int c = 0; c < N; c++) begin
            chk($sformatf("avg%0d", c), 32'(avg[c*SW +: SW]), 32'(m_sum(c) / W));
            chk($sformatf("valid%0d", c), 32'(avg_valid[c]), 32'(m_cnt[c] == W));
        end
        chk("state", 32'(state), 32'(m_state));
    endtask

    // One clock: check at negedge, advance model at posedge, return at posedge+1.
    task automatic cycle();
        int g;
        @(negedge clk);
        g = exp_grant();
        obs_gnt   = gnt;
        obs_state = state;
        chk("gnt", 32'(gnt), (g < 0) ? 32'd0 : (32'd1 << g));
        check_outputs();
        @(posedge clk);
        if (!rst_n) begin
            m_clear();
            m_state = 0;
        end else if (flush && m_state != 2) begin
            m_clear();
            m_state = 2;
        end else if (m_state == 2) begin
            m_state = 0;
        end else if (g >= 0) begin
            void'(m_win[g].pop_front());
            m_win[g].push_back(int'(sample[g*SW +: SW]));
            if (m_cnt[g] < W) m_cnt[g]++;
            m_rr    = (g + 1) % N;
            m_state = 1;
        end
        #1;
    endtask

    initial begin
        int exp_seq [6];
        int ch1_vals [4];
        exp_seq  = '{1, 2, 4, 1, 2, 4};
        ch1_vals = '{1, 2, 3, 0};
        rst_n = 1'b0; ena = 1'b1; flush = 1'b0; req = '1; sample = '0;
        m_clear();
        m_state = 0;
        obs_gnt = '0;
        obs_state = '0;

        // Reset held with every channel requesting.
        repeat (2) begin
            cycle();
            chk("gnt_in_reset", 32'(obs_gnt), 32'd0);
        end
        rst_n = 1'b1; req = '0;
        cycle();
        chk("state_after_reset", 32'(obs_state), 32'd0);

        // Full rotation.
        req = '1;
        sample = {2'd3, 2'd2, 2'd1};
        for (int i = 0; i < 6; i++) begin
            cycle();
            chk($sformatf("rr_seq%0d", i), 32'(obs_gnt), 32'(exp_seq[i]));
        end
        chk("state_run", 32'(state), 32'd1);

        // ch0 alone: 3,3,3,3 then 0.
        flush = 1'b1; req = '0;
        cycle();
        flush = 1'b0;
        cycle();
        req = 3'b001; sample = {2'd0, 2'd0, 2'd3};
        repeat (3) cycle();
        chk("ch0_not_full", 32'(avg_valid[0]), 32'd0);
        cycle();
        chk("ch0_full_valid", 32'(avg_valid[0]), 32'd1);
        chk("ch0_full_avg", 32'(avg[1:0]), 32'd3);
        sample[1:0] = 2'd0;
        cycle();
        chk("ch0_drop_avg", 32'(avg[1:0]), 32'd2);
        chk("ch0_drop_valid", 32'(avg_valid[0]), 32'd1);

        // Fill ch1, then flush while others request.
        req = 3'b010;
        for (int i = 0; i < 4; i++) begin
            sample[3:2] = 2'(ch1_vals[i]);
            cycle();
        end
        chk("ch1_full_avg", 32'(avg[3:2]), 32'd1);
        req = 3'b111; flush = 1'b1;
        cycle();
        chk("flush_gnt_k", 32'(obs_gnt), 32'd0);
        chk("flush_valid_cleared", 32'(avg_valid), 32'd0);
        chk("flush_avg_cleared", 32'(avg), 32'd0);
        flush = 1'b0;
        cycle();
        chk("flush_gnt_k1", 32'(obs_gnt), 32'd0);
        chk("flush_state", 32'(obs_state), 32'd2);
        cycle();
        chk("post_flush_gnt", 32'(obs_gnt), 32'd1);
        chk("post_flush_state", 32'(obs_state), 32'd0);

        // Enable low mid-fill, rr saved at 1.
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("ena_off_gnt", 32'(obs_gnt), 32'd0);
        end
        ena = 1'b1;
        cycle();
        chk("ena_resume_gnt", 32'(obs_gnt), 32'd2);

        // Async reset between edges with 3 samples in ch2.
        flush = 1'b1; req = '0;
        cycle();
        flush = 1'b0;
        cycle();
        req = 3'b100; sample = {2'd2, 2'd0, 2'd0};
        repeat (3) cycle();
        chk("ch2_partial_avg", 32'(avg[5:4]), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_avg", 32'(avg), 32'd0);
        chk("async_state", 32'(state), 32'd0);
        chk("async_gnt", 32'(gnt), 32'd0);
        #1 rst_n = 1'b1;
        m_clear();
        m_state = 0;
        repeat (3) cycle();
        chk("ch2_refill_not_valid", 32'(avg_valid[2]), 32'd0);
        cycle();
        chk("ch2_refill_valid", 32'(avg_valid[2]), 32'd1);
        chk("ch2_refill_avg", 32'(avg[5:4]), 32'd2);

        // Randomized traffic; a channel's sample changes only when idle or just granted.
        for (int k = 0; k < 400; k++) begin
            for (int c = 0; c < N; c++) begin
                if (!req[c] || obs_gnt[c]) begin
                    req[c] = ($urandom_range(0, 3) != 0);
                    sample[c*SW +: SW] = 2'($urandom_range(0, 3));
                end
            end
            ena   = ($urandom_range(0, 9) != 0);
            flush = ($urandom_range(0, 29) == 0);
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
